// File: rtl/obi_dcache_bridge_if.sv
// OBI data-port bundle between the CPU and the dcache bridge.
// master = CPU side, slave = bridge side.
interface obi_dcache_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              gnt;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/obi_dcache_bridge.sv
// OBI to dcache_core bridge: tagged outstanding requests, in-order retire,
// drain-then-flush sequencer. Perf counters under DCACHE_BRIDGE_PERF_EN.
module obi_dcache_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TAG_W = 11,
  parameter int MAX_OUT = 4,
  parameter logic [ADDR_W-1:0] CACHE_LIMIT = ADDR_W'(32'h8000_0000)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  obi_dcache_bridge_if.slave  obi,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_wr_o,
  output logic                mem_rd_o,
  output logic [DATA_W/8-1:0] mem_wr_o,
  output logic                mem_cacheable_o,
  output logic [TAG_W-1:0]    mem_req_tag_o,
  output logic                mem_flush_o,
  output logic                mem_invalidate_o,
  output logic                mem_writeback_o,
  input  logic                mem_accept_i,
  input  logic                mem_ack_i,
  input  logic                mem_error_i,
  input  logic [TAG_W-1:0]    mem_resp_tag_i,
  input  logic [DATA_W-1:0]   mem_data_rd_i,
  input  logic                flush_req_i,
  output logic                flush_done_o,
  output logic                protocol_err_o,
  output logic [31:0]         perf_req_cnt_o,
  output logic [31:0]         perf_stall_cnt_o
);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [MAX_OUT-1:0] slot_vld;
  logic [DATA_W-1:0] slot_data [MAX_OUT];
  logic              slot_err  [MAX_OUT];

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              done_q;
  logic              perr_q;

  logic              can_issue;
  logic              grant;
  logic [PW-1:0]     tag_lo;
  logic [PW-1:0]     rel;
  logic              tag_hi_ok;
  logic              in_win;
  logic              ack_ok;
  logic              bypass;
  logic              retire;

  assign can_issue = (state == IDLE) && (cnt < CW'(MAX_OUT));
  assign grant     = obi.req & can_issue & mem_accept_i;

  assign obi.gnt    = grant;
  assign obi.rvalid = rvalid_q;
  assign obi.rdata  = rdata_q;
  assign obi.err    = err_q;

  assign mem_rd_o  = obi.req & ~obi.we & can_issue;
  assign mem_wr_o  = (obi.req & obi.we & can_issue) ? obi.be : '0;
  assign mem_addr_o    = obi.addr;
  assign mem_data_wr_o = obi.wdata;
  assign mem_req_tag_o = TAG_W'(wr_ptr);
  assign mem_cacheable_o  = obi.addr < CACHE_LIMIT;
  assign mem_flush_o      = state == FLUSH;
  assign mem_invalidate_o = 1'b0;
  assign mem_writeback_o  = 1'b0;
  assign flush_done_o     = done_q;
  assign protocol_err_o   = perr_q;

  // An ack is legal only for a tag inside the in-flight window
  // [rd_ptr, rd_ptr+cnt) whose slot has not been filled yet.
  assign tag_lo    = mem_resp_tag_i[PW-1:0];
  assign tag_hi_ok = (mem_resp_tag_i >> PW) == '0;
  assign rel       = tag_lo - rd_ptr;
  assign in_win    = CW'(rel) < cnt;
  assign ack_ok    = mem_ack_i & tag_hi_ok & in_win & ~slot_vld[tag_lo];
  assign bypass    = ack_ok & (tag_lo == rd_ptr);
  assign retire    = slot_vld[rd_ptr] | bypass;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      slot_vld <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (retire) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(grant) - CW'(retire);
      if (ack_ok & ~bypass) slot_vld[tag_lo] <= 1'b1;
      if (retire) slot_vld[rd_ptr] <= 1'b0;
      rvalid_q <= retire;
      if (retire) begin
        rdata_q <= slot_vld[rd_ptr] ? slot_data[rd_ptr] : mem_data_rd_i;
        err_q   <= slot_vld[rd_ptr] ? slot_err[rd_ptr] : mem_error_i;
      end
      perr_q <= perr_q | (mem_ack_i & ~ack_ok);
      done_q <= 1'b0;
      unique case (state)
        IDLE:  if (flush_req_i) state <= DRAIN;
        DRAIN: if (cnt == '0 && !retire) state <= FLUSH;
        FLUSH: if (mem_accept_i) begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (ack_ok & ~bypass) begin
      slot_data[tag_lo] <= mem_data_rd_i;
      slot_err[tag_lo]  <= mem_error_i;
    end
  end

`ifdef DCACHE_BRIDGE_PERF_EN
  logic [31:0] preq_q;
  logic [31:0] pstall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      preq_q   <= '0;
      pstall_q <= '0;
    end else begin
      if (grant) preq_q <= preq_q + 32'd1;
      if (obi.req & ~grant) pstall_q <= pstall_q + 32'd1;
    end
  end

  assign perf_req_cnt_o   = preq_q;
  assign perf_stall_cnt_o = pstall_q;
`else
  assign perf_req_cnt_o   = '0;
  assign perf_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_obi_dcache_bridge.sv
// Bench for obi_dcache_bridge: directed plan steps plus random traffic,
// checked against an issue-order response queue model.
module tb_obi_dcache_bridge;
  localparam int MAX_OUT = 4;
  localparam logic [31:0] LIMIT = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, rdata_in;
  logic        mem_rd;
  logic [3:0]  mem_wr;
  logic        cach;
  logic [10:0] rtag, atag;
  logic        mflush, minv, mwb;
  logic        accept, ack, aerr;
  logic        freq, fdone, perr;
  logic [31:0] preq, pstall;

  obi_dcache_bridge_if bus ();

  always #5 clk = ~clk;

  obi_dcache_bridge dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .obi              (bus),
    .mem_addr_o       (mem_addr),
    .mem_data_wr_o    (mem_wdata),
    .mem_rd_o         (mem_rd),
    .mem_wr_o         (mem_wr),
    .mem_cacheable_o  (cach),
    .mem_req_tag_o    (rtag),
    .mem_flush_o      (mflush),
    .mem_invalidate_o (minv),
    .mem_writeback_o  (mwb),
    .mem_accept_i     (accept),
    .mem_ack_i        (ack),
    .mem_error_i      (aerr),
    .mem_resp_tag_i   (atag),
    .mem_data_rd_i    (rdata_in),
    .flush_req_i      (freq),
    .flush_done_o     (fdone),
    .protocol_err_o   (perr),
    .perf_req_cnt_o   (preq),
    .perf_stall_cnt_o (pstall)
  );

  typedef struct {
    int          tag;
    bit          got;
    logic [31:0] d;
    bit          e;
  } ent_t;

  ent_t        q[$];
  int          next_tag;
  bit          blocked, exp_flush, exp_fdone, exp_perr;
  bit          exp_rv, exp_err;
  logic [31:0] exp_rdata;
  int unsigned exp_preq, exp_pstall;
  int          n_tests = 0;
  int          n_fail = 0;
  int          base, u, w;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    bus.req = 0; bus.we = 0; bus.be = '0;
    bus.addr = '0; bus.wdata = '0;
    ack = 0; aerr = 0; atag = '0; rdata_in = '0;
    accept = 1; freq = 0;
  endtask

  task automatic tick();
    bit can, eg, found;
    #1;
    if (rst) begin
      q.delete();
      next_tag = 0; exp_perr = 0; exp_rdata = '0;
      exp_rv = 0; exp_err = 0; exp_preq = 0; exp_pstall = 0;
    end else begin
      can = !blocked && q.size() < MAX_OUT;
      eg = bus.req && can && accept;
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("mem_rd", 32'(mem_rd), 32'(bus.req && !bus.we && can));
      chk("mem_wr", 32'(mem_wr), (bus.req && bus.we && can) ? 32'(bus.be) : 32'd0);
      chk("req_tag", 32'(rtag), 32'(next_tag));
      chk("cacheable", 32'(cach), 32'(bus.addr < LIMIT));
      chk("mem_addr", mem_addr, bus.addr);
      chk("mem_wdata", mem_wdata, bus.wdata);
      chk("mem_flush", 32'(mflush), 32'(exp_flush));
      chk("inv_wb", 32'({minv, mwb}), 32'd0);
      exp_rv = 0;
      if (ack) begin
        found = 0;
        foreach (q[i])
          if (!found && q[i].tag == int'(atag) && !q[i].got) begin
            q[i].got = 1; q[i].d = rdata_in; q[i].e = aerr; found = 1;
          end
        if (!found) exp_perr = 1;
      end
      if (q.size() > 0 && q[0].got) begin
        exp_rv = 1; exp_rdata = q[0].d; exp_err = q[0].e;
        void'(q.pop_front());
      end
      if (eg) begin
        q.push_back('{tag: next_tag, got: 0, d: '0, e: 0});
        next_tag = (next_tag + 1) % MAX_OUT;
        exp_preq++;
      end
      if (bus.req && !eg) exp_pstall++;
    end
    @(posedge clk);
    #1;
    chk("rvalid", 32'(bus.rvalid), 32'(exp_rv));
    chk("rdata", bus.rdata, exp_rdata);
    if (exp_rv) chk("rerr", 32'(bus.err), 32'(exp_err));
    chk("protocol_err", 32'(perr), 32'(exp_perr));
    chk("flush_done", 32'(fdone), 32'(exp_fdone));
`ifdef DCACHE_BRIDGE_PERF_EN
    chk("perf_req", preq, exp_preq);
    chk("perf_stall", pstall, exp_pstall);
`else
    chk("perf_req", preq, 32'd0);
    chk("perf_stall", pstall, 32'd0);
`endif
    exp_fdone = 0;
    @(negedge clk);
  endtask

  function automatic int pick_pending();
    int idx[$];
    foreach (q[i]) if (!q[i].got) idx.push_back(i);
    if (idx.size() == 0) return -1;
    return idx[$urandom_range(idx.size() - 1)];
  endfunction

  task automatic drain();
    int k;
    bus.req = 0;
    for (int i = 0; i < 64 && q.size() > 0; i++) begin
      k = pick_pending();
      ack = (k >= 0);
      if (k >= 0) begin
        atag = 11'(q[k].tag); rdata_in = $urandom; aerr = 0;
      end
      tick();
    end
    ack = 0;
    chk("drain_bound", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int ord[4];
    int k;
    ord = '{2, 0, 3, 1};
    set_idle();
    rst = 1; blocked = 0; exp_flush = 0; exp_fdone = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 0;

    // single read
    bus.req = 1; bus.addr = 32'h0000_1000;
    tick();
    bus.req = 0; ack = 1; atag = 0; rdata_in = 32'hDEAD_BEEF;
    tick();
    ack = 0;
    chk("single_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("single_rvalid", 32'(bus.rvalid), 32'd1);

    // four reads, acks out of order, fifth held until first retire
    base = next_tag;
    bus.req = 1;
    for (int i = 0; i < 4; i++) begin
      bus.addr = 32'h2000 + 32'(i * 4);
      tick();
    end
    bus.addr = 32'h2010;
    for (int i = 0; i < 4; i++) begin
      ack = 1; atag = 11'((base + ord[i]) % MAX_OUT);
      rdata_in = 32'hA000_0000 + 32'(ord[i]);
      tick();
      if (i == 1) chk("ooo_first", bus.rdata, 32'hA000_0000);
    end
    bus.req = 0;
    ack = 1; atag = 11'(base); rdata_in = 32'h5555_0005;
    tick();
    ack = 0;
    tick();

    // write with error
    w = next_tag;
    bus.req = 1; bus.we = 1; bus.be = 4'b0011;
    bus.addr = 32'h9000_0000; bus.wdata = $urandom;
    tick();
    bus.req = 0; bus.we = 0;
    ack = 1; atag = 11'(w); aerr = 1; rdata_in = 32'h0;
    tick();
    ack = 0; aerr = 0;
    chk("wr_err", 32'(bus.err), 32'd1);

    // flush with two outstanding reads
    bus.addr = 32'h3000;
    u = next_tag;
    bus.req = 1; tick(); tick();
    bus.req = 0; freq = 1; tick();
    freq = 0; blocked = 1; bus.req = 1;
    ack = 1; atag = 11'(u); rdata_in = 32'h1111_0000; tick();
    atag = 11'((u + 1) % MAX_OUT); rdata_in = 32'h1111_0001; tick();
    ack = 0; tick();
    exp_flush = 1; accept = 0;
    repeat (3) tick();
    accept = 1; exp_fdone = 1; tick();
    exp_flush = 0; tick();
    chk("flush_done_gone", 32'(fdone), 32'd0);
    blocked = 0;
    u = next_tag;
    tick();
    bus.req = 0; ack = 1; atag = 11'(u); rdata_in = 32'h2222_0000;
    tick();
    ack = 0;

    // unexpected ack
    u = next_tag;
    bus.req = 1; tick();
    bus.req = 0; ack = 1; atag = 11'((u + 3) % MAX_OUT); rdata_in = 32'hBAD0_BAD0;
    tick();
    chk("perr_set", 32'(perr), 32'd1);
    atag = 11'(u); rdata_in = 32'h600D_600D;
    tick();
    ack = 0;
    chk("perr_sticky", 32'(perr), 32'd1);
    chk("after_bad_rdata", bus.rdata, 32'h600D_600D);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      bus.req = ($urandom_range(9) < 7);
      bus.we = ($urandom_range(9) < 3);
      bus.be = 4'($urandom);
      bus.addr = $urandom;
      bus.wdata = $urandom;
      accept = ($urandom_range(3) != 0);
      k = pick_pending();
      ack = 0;
      if (k >= 0 && $urandom_range(1) == 1) begin
        ack = 1; atag = 11'(q[k].tag);
      end else if ($urandom_range(15) == 0) begin
        ack = 1; atag = 11'($urandom_range(MAX_OUT - 1));
      end
      rdata_in = $urandom;
      aerr = ($urandom_range(7) == 0);
      tick();
    end
    accept = 1; aerr = 0;
    drain();

    // reset with three outstanding
    bus.we = 0; bus.addr = 32'h4000; bus.req = 1;
    repeat (3) tick();
    bus.req = 0; rst = 1; ack = 1; atag = 0; rdata_in = 32'h7777_7777;
    tick();
    rst = 0; ack = 0;
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_perf", preq | pstall, 32'd0);
    bus.req = 1;
    repeat (5) tick();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/obi_dcache_bridge.md
Name: obi_dcache_bridge

Overview:
- Parametrised OBI-to-dcache_core bridge that sits between the CPU data OBI port and dcache_core.
- Supports up to MAX_OUT outstanding requests, tagged with mem_req_tag_o. Out-of-order cache responses are reordered so the CPU sees in-order obi_rvalid_o.
- Adds a software flush sequencer (drain, then flush), a parametrised cacheable limit, and error/protocol reporting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8.
- TAG_W, 11, dcache tag width; must be >= log2(MAX_OUT).
- MAX_OUT, 4, maximum outstanding requests; power of two, 2..16.
- CACHE_LIMIT, 32'h8000_0000, addresses strictly below this are cacheable.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- obi_req_i  in  1  OBI request
- obi_gnt_o  out  1  OBI grant
- obi_we_i  in  1  write enable
- obi_be_i  in  BE_W  byte enables
- obi_addr_i  in  ADDR_W  address
- obi_wdata_i  in  DATA_W  write data
- obi_rvalid_o  out  1  response valid (registered)
- obi_rdata_o  out  DATA_W  response data (registered)
- obi_err_o  out  1  response error (registered)
- mem_addr_o  out  ADDR_W  cache address
- mem_data_wr_o  out  DATA_W  cache write data
- mem_rd_o  out  1  read request
- mem_wr_o  out  BE_W  write strobes
- mem_cacheable_o  out  1  cacheable attribute
- mem_req_tag_o  out  TAG_W  request tag
- mem_flush_o  out  1  flush command
- mem_invalidate_o  out  1  tied 0
- mem_writeback_o  out  1  tied 0
- mem_accept_i  in  1  cache accepts command
- mem_ack_i  in  1  cache response valid
- mem_error_i  in  1  cache response error
- mem_resp_tag_i  in  TAG_W  response tag
- mem_data_rd_i  in  DATA_W  response data
- flush_req_i  in  1  flush request (level; sampled in IDLE)
- flush_done_o  out  1  one-cycle pulse when flush accepted
- protocol_err_o  out  1  sticky; unexpected ack seen
- perf_req_cnt_o  out  32  granted request count (see option)
- perf_stall_cnt_o  out  32  stalled request cycles (see option)

Behaviour:
- Reset (rst_i=1 at posedge):
  - all registered outputs 0, including obi_rvalid_o, obi_rdata_o, obi_err_o, flush_done_o, protocol_err_o and the perf counters;
  - pointers wr_ptr and rd_ptr = 0, outstanding count cnt = 0, all slot-valid bits cleared, FSM = IDLE;
  - responses in flight are discarded.
- Issue condition: can_issue = (state==IDLE) & (cnt<MAX_OUT).
- Command outputs (combinational):
  - mem_rd_o = obi_req_i & ~obi_we_i & can_issue;
  - mem_wr_o = (obi_req_i & obi_we_i & can_issue) ? obi_be_i : 0;
  - mem_addr_o, mem_data_wr_o pass through;
  - mem_req_tag_o = wr_ptr zero-extended to TAG_W;
  - mem_cacheable_o = (obi_addr_i < CACHE_LIMIT).
- Grant: obi_gnt_o = obi_req_i & can_issue & mem_accept_i. On grant: wr_ptr++ (wraps modulo MAX_OUT), cnt++.
- Response capture: a mem_ack_i whose tag is outstanding (slot not yet valid and within the in-flight window) writes data and error into slot[tag] and sets its valid bit.
- Unexpected ack: tag not outstanding, or slot already valid → response dropped, protocol_err_o set to 1 and held until reset.
- Retire rule, evaluated each cycle:
  - candidate = slot[rd_ptr] if valid; otherwise the same-cycle ack with tag==rd_ptr (bypass);
  - if a candidate exists: next cycle obi_rvalid_o=1 with its rdata/err, the slot is cleared and rd_ptr++;
  - otherwise obi_rvalid_o=0.
  - Ack-to-rvalid latency is exactly 1 cycle when in order. Obi_rdata_o holds its last value when rvalid=0.
- cnt update: decrements on retire; a grant and a retire in the same cycle leave cnt unchanged. cnt never exceeds MAX_OUT and never underflows.
- Flush FSM:
  - IDLE: flush_req_i=1 → DRAIN. A grant may still occur in the same cycle as the transition.
  - DRAIN: no grants; once cnt==0 and no retire is pending → FLUSH.
  - FLUSH: mem_flush_o=1, mem_rd_o/mem_wr_o=0; on mem_accept_i → DONE.
  - DONE: flush_done_o=1 for one cycle → IDLE.
- obi_gnt_o is never asserted outside IDLE. Reset in any state returns to IDLE immediately.

Optional Feature:
- Macro: DCACHE_BRIDGE_PERF_EN.
- Defined:
  - perf_req_cnt_o increments on every grant;
  - perf_stall_cnt_o increments each cycle that obi_req_i=1 & obi_gnt_o=0;
  - both counters are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Single read to 0x0000_1000, accept=1, ack tag 0 with data 0xDEADBEEF one cycle later → rvalid one cycle after ack, rdata 0xDEADBEEF, err=0, mem_cacheable_o=1.
- Four back-to-back reads with MAX_OUT=4, acks returned in tag order 2,0,3,1 → rvalid data delivered in order tags 0,1,2,3; a fifth request is not granted until the first retire.
- Write to 0x9000_0000, be=4'b0011, ack with mem_error_i=1 → mem_wr_o=0011, mem_cacheable_o=0, obi_err_o=1 on rvalid.
- flush_req_i with two outstanding reads → no grants until both retire, then mem_flush_o=1 is held through 3 cycles of accept=0; flush_done_o pulses once after accept.
- Ack with tag 3 while only tag 0 is outstanding → ack dropped, protocol_err_o=1 and stays 1; normal traffic still completes.
- Assert rst_i with 3 outstanding requests mid-stream → next cycle cnt=0, rvalid=0, FSM IDLE; perf counters (PERF_EN build) read 0.
